// File: rtl/dcache_wb_param.sv
// Direct-mapped, write-back, write-allocate data cache. Lines are evicted and refilled one word
// at a time over a req/ack memory port. CPU side uses an enable strobe and finished pulses.
module dcache_wb_param #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LINES          = 8,
   parameter int unsigned WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  memwrite,
   input  logic                  enable,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  read_finished,
   output logic                  write_finished,
   output logic                  busy,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   localparam int unsigned OB = $clog2(WORDS_PER_LINE);
   localparam int unsigned IB = $clog2(LINES);
   localparam int unsigned TW = ADDR_WIDTH - OB - IB;
   localparam logic [OB-1:0] OffLast = '1;

   typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StRespond} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [OB-1:0]         k_q, k_d;
   logic                  busy_q, busy_d;
   logic                  rd_fin_q, rd_fin_d;
   logic                  wr_fin_q, wr_fin_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic [LINES-1:0]      dirty_q, dirty_d;

   // Storage arrays; validity is tracked separately so these need no reset.
   logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS_PER_LINE];
   logic [TW-1:0]         tag_mem  [LINES];

   logic                  dmem_we;
   logic [OB-1:0]         dmem_word;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  tag_we;

   logic [OB-1:0]         req_off;
   logic [IB-1:0]         req_idx;
   logic [TW-1:0]         req_tag;
   logic [TW-1:0]         victim_tag;
   logic                  hit;
   logic                  k_last;
   logic                  ack_valid;
   logic [DATA_WIDTH-1:0] hit_word;
   logic [DATA_WIDTH-1:0] fill_word;

   assign req_off    = addr_q[OB-1:0];
   assign req_idx    = addr_q[OB+IB-1:OB];
   assign req_tag    = addr_q[ADDR_WIDTH-1:OB+IB];
   assign victim_tag = tag_mem[req_idx];
   assign hit        = valid_q[req_idx] && (victim_tag == req_tag);
   assign k_last     = (k_q == OffLast);
   assign ack_valid  = mem_req_q && mem_ack;
   assign hit_word   = data_mem[req_idx][req_off];
   // On the final refill ack the last word is still on mem_rdata, not yet in the array.
   assign fill_word  = (req_off == k_q) ? mem_rdata : hit_word;

   // Next-state logic for the controller, the memory port and the line status bits.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      k_d         = k_q;
      busy_d      = busy_q;
      rd_fin_d    = rd_fin_q;
      wr_fin_d    = wr_fin_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      dmem_we     = 1'b0;
      dmem_word   = k_q;
      dmem_wdata  = mem_rdata;
      tag_we      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               addr_d  = addr;
               wdata_d = write_data;
               we_d    = memwrite;
               busy_d  = 1'b1;
               state_d = StLookup;
            end
         end
         StLookup: begin
            k_d = '0;
            if (hit) begin
               state_d = StRespond;
               if (we_q) begin
                  wr_fin_d = 1'b1;
               end else begin
                  rd_fin_d = 1'b1;
                  rdata_d  = hit_word;
               end
            end else if (dirty_q[req_idx]) begin
               state_d     = StWriteback;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {victim_tag, req_idx, {OB{1'b0}}};
               mem_wdata_d = data_mem[req_idx][0];
            end else begin
               state_d    = StRefill;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag, req_idx, {OB{1'b0}}};
            end
         end
         StWriteback: begin
            if (ack_valid) begin
               mem_req_d = 1'b0;
               if (k_last) begin
                  k_d              = '0;
                  dirty_d[req_idx] = 1'b0;
                  state_d          = StRefill;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else if (!mem_req_q) begin
               // Idle gap is over: present the next victim word.
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {victim_tag, req_idx, k_q};
               mem_wdata_d = data_mem[req_idx][k_q];
            end
         end
         StRefill: begin
            if (ack_valid) begin
               mem_req_d  = 1'b0;
               dmem_we    = 1'b1;
               dmem_word  = k_q;
               dmem_wdata = mem_rdata;
               if (k_last) begin
                  k_d              = '0;
                  tag_we           = 1'b1;
                  valid_d[req_idx] = 1'b1;
                  state_d          = StRespond;
                  if (we_q) begin
                     wr_fin_d = 1'b1;
                  end else begin
                     rd_fin_d = 1'b1;
                     rdata_d  = fill_word;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {req_tag, req_idx, k_q};
            end
         end
         StRespond: begin
            rd_fin_d = 1'b0;
            wr_fin_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = StIdle;
            if (we_q) begin
               // Store merge happens here so a store miss lands on top of the refilled line.
               dmem_we          = 1'b1;
               dmem_word        = req_off;
               dmem_wdata       = wdata_q;
               dirty_d[req_idx] = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Controller and output registers; reset discards any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         k_q         <= '0;
         busy_q      <= 1'b0;
         rd_fin_q    <= 1'b0;
         wr_fin_q    <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         k_q         <= k_d;
         busy_q      <= busy_d;
         rd_fin_q    <= rd_fin_d;
         wr_fin_q    <= wr_fin_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Data and tag array writes.
   always_ff @(posedge clk) begin
      if (dmem_we) begin
         data_mem[req_idx][dmem_word] <= dmem_wdata;
      end
      if (tag_we) begin
         tag_mem[req_idx] <= req_tag;
      end
   end

   assign read_data      = rdata_q;
   assign read_finished  = rd_fin_q;
   assign write_finished = wr_fin_q;
   assign busy           = busy_q;
   assign mem_req        = mem_req_q;
   assign mem_we         = mem_we_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb_param.sv
// Bench for dcache_wb_param: table of CPU accesses checked against a reference cache model,
// plus hand-written enable-during-miss and reset-during-refill sequences.
module tb_dcache_wb_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        memwrite;
   logic        enable;
   logic [31:0] read_data;
   logic        read_finished;
   logic        write_finished;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack = 1'b0;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] wd;
      logic        we;
      logic [31:0] rd;
      int          wb;
      int          rf;
   } vec_t;

   txn_t        exp_txn_q[$];
   txn_t        obs_txn_q[$];
   logic [31:0] exp_rd_q[$];

   // Reference cache contents
   logic        m_valid[8];
   logic        m_dirty[8];
   logic [26:0] m_tag[8];
   logic [31:0] m_data[8][4];

   dcache_wb_param dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr          (addr),
      .write_data    (write_data),
      .memwrite      (memwrite),
      .enable        (enable),
      .read_data     (read_data),
      .read_finished (read_finished),
      .write_finished(write_finished),
      .busy          (busy),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack)
   );

   always #5 clk = ~clk;

   // Backing memory: ack in the 4th cycle of a request, data derived from the address.
   int ack_cnt = 0;
   assign mem_rdata = {16'hA5A5, mem_addr[15:0]};

   always @(negedge clk) begin
      txn_t t;
      if (!rst_n) begin
         mem_ack <= 1'b0;
         ack_cnt <= 0;
      end else if (mem_req && !mem_ack) begin
         if (ack_cnt == 3) begin
            mem_ack <= 1'b1;
            ack_cnt <= 0;
            t.we = mem_we;
            t.a  = mem_addr;
            t.d  = mem_wdata;
            obs_txn_q.push_back(t);
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end else begin
         mem_ack <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, " read_data"}, 64'(read_data), 64'd0);
      chk({nm, " read_finished"}, 64'(read_finished), 64'd0);
      chk({nm, " write_finished"}, 64'(write_finished), 64'd0);
      chk({nm, " busy"}, 64'(busy), 64'd0);
      chk({nm, " mem_req"}, 64'(mem_req), 64'd0);
      chk({nm, " mem_we"}, 64'(mem_we), 64'd0);
      chk({nm, " mem_addr"}, 64'(mem_addr), 64'd0);
      chk({nm, " mem_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   // Reference model: pushes the memory traffic an access should produce.
   task automatic model_access(input logic [31:0] a, input logic [31:0] wd, input logic we);
      logic [2:0]  idx;
      logic [1:0]  off;
      logic [26:0] tg;
      txn_t        t;
      int          i;
      idx = a[4:2];
      off = a[1:0];
      tg  = a[31:5];
      i   = int'(idx);
      if (!(m_valid[i] && m_tag[i] == tg)) begin
         if (m_valid[i] && m_dirty[i]) begin
            for (int k = 0; k < 4; k++) begin
               t.we = 1'b1;
               t.a  = {m_tag[i], idx, 2'(k)};
               t.d  = m_data[i][k];
               exp_txn_q.push_back(t);
            end
         end
         for (int k = 0; k < 4; k++) begin
            t.we = 1'b0;
            t.a  = {tg, idx, 2'(k)};
            t.d  = '0;
            exp_txn_q.push_back(t);
            m_data[i][k] = {16'hA5A5, t.a[15:0]};
         end
         m_valid[i] = 1'b1;
         m_dirty[i] = 1'b0;
         m_tag[i]   = tg;
      end
      if (we) begin
         m_data[i][off] = wd;
         m_dirty[i]     = 1'b1;
      end
   endtask

   task automatic drain_txns(input string nm, output int n_wr, output int n_rd);
      txn_t o;
      txn_t e;
      n_wr = 0;
      n_rd = 0;
      chk({nm, " txn count"}, 64'(obs_txn_q.size()), 64'(exp_txn_q.size()));
      while (obs_txn_q.size() > 0 && exp_txn_q.size() > 0) begin
         o = obs_txn_q.pop_front();
         e = exp_txn_q.pop_front();
         if (o.we) n_wr++;
         else n_rd++;
         chk({nm, " txn we"}, 64'(o.we), 64'(e.we));
         chk({nm, " txn addr"}, 64'(o.a), 64'(e.a));
         if (e.we) chk({nm, " txn wdata"}, 64'(o.d), 64'(e.d));
      end
      obs_txn_q.delete();
      exp_txn_q.delete();
   endtask

   task automatic do_req(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [31:0] rd, input int wb, input int rf);
      int          cyc;
      int          req_cyc;
      int          n_wr;
      int          n_rd;
      int          n;
      int          exp_lat;
      logic [31:0] e_rd;
      n       = wb + rf;
      exp_lat = (n == 0) ? 2 : 5 * n + 1;
      model_access(a, wd, we);
      if (!we) exp_rd_q.push_back(rd);
      @(negedge clk);
      addr       = a;
      write_data = wd;
      memwrite   = we;
      enable     = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      cyc     = 1;
      req_cyc = 0;
      while (!(read_finished || write_finished) && cyc < 300) begin
         if (mem_req) req_cyc++;
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
      chk({nm, " busy"}, 64'(busy), 64'd1);
      chk({nm, " read_finished"}, 64'(read_finished), 64'(!we));
      chk({nm, " write_finished"}, 64'(write_finished), 64'(we));
      if (!we) begin
         e_rd = exp_rd_q.pop_front();
         chk({nm, " read_data"}, 64'(read_data), 64'(e_rd));
      end
      chk({nm, " req cycles"}, 64'(req_cyc), 64'(4 * n));
      @(negedge clk);
      chk({nm, " pulse end"}, 64'({read_finished, write_finished, busy}), 64'd0);
      drain_txns(nm, n_wr, n_rd);
      chk({nm, " wb words"}, 64'(n_wr), 64'(wb));
      chk({nm, " rf words"}, 64'(n_rd), 64'(rf));
   endtask

   initial begin
      vec_t        vecs[10];
      int          pulses;
      int          wpulses;
      int          n_wr;
      int          n_rd;
      logic [31:0] got_rd;

      vecs[0] = '{32'd1,  32'd0,       1'b0, 32'hA5A50001, 0, 4};
      vecs[1] = '{32'd2,  32'd0,       1'b0, 32'hA5A50002, 0, 0};
      vecs[2] = '{32'd1,  32'd7,       1'b1, 32'd0,        0, 0};
      vecs[3] = '{32'd1,  32'd0,       1'b0, 32'd7,        0, 0};
      vecs[4] = '{32'd32, 32'd0,       1'b0, 32'hA5A50020, 4, 4};
      vecs[5] = '{32'd1,  32'd0,       1'b0, 32'hA5A50001, 0, 4};
      vecs[6] = '{32'd9,  32'h1234,    1'b1, 32'd0,        0, 4};
      vecs[7] = '{32'd9,  32'd0,       1'b0, 32'h1234,     0, 0};
      vecs[8] = '{32'd41, 32'h55,      1'b1, 32'd0,        4, 4};
      vecs[9] = '{32'd41, 32'd0,       1'b0, 32'h55,       0, 0};

      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end

      rst_n      = 1'b0;
      addr       = '0;
      write_data = '0;
      memwrite   = 1'b0;
      enable     = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         do_req($sformatf("v%0d", i), vecs[i].a, vecs[i].wd, vecs[i].we, vecs[i].rd,
                vecs[i].wb, vecs[i].rf);
      end

      // Enable pulsed while a miss is in flight must be dropped.
      model_access(32'd64, 32'd0, 1'b0);
      @(negedge clk);
      addr     = 32'd64;
      memwrite = 1'b0;
      enable   = 1'b1;
      @(negedge clk);
      enable  = 1'b0;
      pulses  = 0;
      wpulses = 0;
      got_rd  = '0;
      for (int c = 1; c <= 60; c++) begin
         if (c == 5) begin
            enable     = 1'b1;
            addr       = 32'd3;
            memwrite   = 1'b1;
            write_data = 32'hDEAD;
         end
         if (c == 6) enable = 1'b0;
         if (read_finished) begin
            pulses++;
            got_rd = read_data;
         end
         if (write_finished) wpulses++;
         @(negedge clk);
      end
      chk("busy enable read pulses", 64'(pulses), 64'd1);
      chk("busy enable write pulses", 64'(wpulses), 64'd0);
      chk("busy enable read_data", 64'(got_rd), 64'hA5A50040);
      chk("busy enable idle", 64'(busy), 64'd0);
      drain_txns("busy enable", n_wr, n_rd);
      chk("busy enable rf words", 64'(n_rd), 64'd4);

      // Asynchronous reset in the middle of a refill.
      @(negedge clk);
      addr     = 32'd96;
      memwrite = 1'b0;
      enable   = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid refill mem_req", 64'(mem_req), 64'd1);
      chk("mid refill read_data held", 64'(read_data), 64'hA5A50040);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      obs_txn_q.delete();
      exp_txn_q.delete();
      @(negedge clk);
      chk("post reset no pulse", 64'({read_finished, write_finished, busy}), 64'd0);
      do_req("post reset load", 32'd1, 32'd0, 1'b0, 32'hA5A50001, 0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
